// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel push-button synchroniser, debouncer and edge detector
module button_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic                any_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Inversion ahead of the chain keeps the all-zero reset state meaning "released".
    logic [CHANNELS-1:0] raw_cond;
    assign raw_cond = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= raw_cond;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [CNT_W-1:0] count;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             sync_bit;
        logic             mismatch;
        logic             accept;

        assign sync_bit = sync_q[SYNC_STAGES-1][ch];
        assign mismatch = sync_bit ^ level_q;
        // Count holds the number of earlier consecutive mismatches, so acceptance
        // lands on the DEBOUNCE_CYCLES-th mismatching cycle.
        assign accept   = mismatch && (count == CNT_MAX);

        always_ff @(posedge clk) begin
            if (!reset) begin
                count     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= enable & accept & sync_bit;
                release_q <= enable & accept & ~sync_bit;
                if (accept) begin
                    level_q <= sync_bit;
                    count   <= '0;
                end else if (mismatch) begin
                    count <= count + 1'b1;
                end else begin
                    count <= '0;
                end
            end
        end

        assign btn_level[ch]   = level_q;
        assign btn_press[ch]   = press_q;
        assign btn_release[ch] = release_q;
    end

    assign any_press = |btn_press;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed and random checks of button_conditioner against a sliding-window model
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [3:0] btn_raw = 4'h0;
    logic [3:0] btn_level, btn_press, btn_release;
    logic       any_press;
    logic [0:0] btn_raw_b = 1'b1;
    logic [0:0] btn_level_b, btn_press_b, btn_release_b;
    logic       any_press_b;

    always #5 clk = ~clk;

    button_conditioner dut_a (
        .clk(clk), .reset(reset), .enable(enable), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .any_press(any_press)
    );

    button_conditioner #(.CHANNELS(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(2), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .btn_raw(btn_raw_b),
        .btn_level(btn_level_b), .btn_press(btn_press_b), .btn_release(btn_release_b),
        .any_press(any_press_b)
    );

    int passes = 0;
    int checks = 0;

    // Model: sample history since reset; a channel flips when the D most recent
    // samples as seen through an S-edge delay all disagree with its level.
    logic [3:0] hist [2][4096];
    int         nsamp [2];
    logic [3:0] m_level [2];
    logic [3:0] m_press [2];
    logic [3:0] m_rel [2];

    logic [3:0] rv;
    logic       r1v;
    int         hold [4];
    int         hold1;
    logic       en_v;
    logic       rst_v;

    function automatic logic [3:0] delayed(input int d, input int idx);
        if (idx < 0) return 4'h0;
        return hist[d][idx % 4096];
    endfunction

    task automatic model_edge(input int d, input logic rs, input logic en, input logic [3:0] s,
                              input int S, input int D, input int nch);
        logic [3:0] newl;
        logic [3:0] smp;
        int t;
        bit ok;
        if (!rs) begin
            nsamp[d] = 0; m_level[d] = 4'h0; m_press[d] = 4'h0; m_rel[d] = 4'h0;
            return;
        end
        t = nsamp[d];
        hist[d][t % 4096] = s & 4'((1 << nch) - 1);
        nsamp[d] = t + 1;
        newl = m_level[d];
        for (int c = 0; c < nch; c++) begin
            ok = 1'b1;
            for (int k = 0; k < D; k++) begin
                smp = delayed(d, t - S - k);
                if (smp[c] == m_level[d][c]) ok = 1'b0;
            end
            if (ok) newl[c] = ~m_level[d][c];
        end
        m_press[d] = en ? (newl & ~m_level[d]) : 4'h0;
        m_rel[d]   = en ? (~newl & m_level[d]) : 4'h0;
        m_level[d] = newl;
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic step(input logic [3:0] r, input logic r1, input logic e, input logic rs);
        @(negedge clk);
        btn_raw = r; btn_raw_b = r1; enable = e; reset = rs;
        @(posedge clk);
        model_edge(0, rs, e, r, 2, 16, 4);
        model_edge(1, rs, e, {3'b000, ~r1}, 3, 2, 1);
        #1;
        check("a_level", btn_level, m_level[0]);
        check("a_press", btn_press, m_press[0]);
        check("a_release", btn_release, m_rel[0]);
        check("a_any", {3'b000, any_press}, {3'b000, |m_press[0]});
        check("b_level", {3'b000, btn_level_b}, m_level[1]);
        check("b_press", {3'b000, btn_press_b}, m_press[1]);
        check("b_release", {3'b000, btn_release_b}, m_rel[1]);
        check("b_any", {3'b000, any_press_b}, {3'b000, |m_press[1]});
    endtask

    initial begin
        nsamp[0] = 0; nsamp[1] = 0;
        for (int d = 0; d < 2; d++) begin
            m_level[d] = 4'h0; m_press[d] = 4'h0; m_rel[d] = 4'h0;
        end

        // held buttons during reset
        repeat (5) step(4'hF, 1'b1, 1'b1, 1'b0);
        check("rst_level", btn_level, 4'h0);
        repeat (17) step(4'hF, 1'b1, 1'b1, 1'b1);
        step(4'hF, 1'b1, 1'b1, 1'b1);
        check("rst_rel_level", btn_level, 4'hF);
        check("rst_rel_press", btn_press, 4'hF);
        check("rst_rel_any", {3'b000, any_press}, 4'h1);
        step(4'hF, 1'b1, 1'b1, 1'b1);
        check("rst_rel_press_gone", btn_press, 4'h0);
        repeat (30) step(4'h0, 1'b1, 1'b1, 1'b1);

        // clean press and release on ch0
        for (int i = 0; i < 40; i++) begin
            step(4'h1, 1'b1, 1'b1, 1'b1);
            if (i == 17) check("ch0_press", btn_press, 4'h1);
        end
        for (int i = 0; i < 30; i++) begin
            step(4'h0, 1'b1, 1'b1, 1'b1);
            if (i == 17) check("ch0_release", btn_release, 4'h1);
        end

        // bouncing ch1
        repeat (4) begin
            repeat (10) step(4'h2, 1'b1, 1'b1, 1'b1);
            repeat (3) step(4'h0, 1'b1, 1'b1, 1'b1);
        end
        check("ch1_bounce_level", btn_level, 4'h0);
        for (int i = 0; i < 20; i++) begin
            step(4'h2, 1'b1, 1'b1, 1'b1);
            if (i == 16) check("ch1_not_early", btn_level, 4'h0);
            if (i == 17) check("ch1_press", btn_press, 4'h2);
        end
        repeat (20) step(4'h0, 1'b1, 1'b1, 1'b1);

        // reset in the middle of a debounce on ch2
        repeat (12) step(4'h4, 1'b1, 1'b1, 1'b1);
        step(4'h4, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(4'h4, 1'b1, 1'b1, 1'b1);
            if (i == 4) check("ch2_orig_edge", btn_press, 4'h0);
            if (i == 17) check("ch2_press", btn_press, 4'h4);
        end
        repeat (20) step(4'h0, 1'b1, 1'b1, 1'b1);

        // enable gating on ch3
        repeat (20) step(4'h8, 1'b1, 1'b0, 1'b1);
        check("ch3_level_gated", btn_level, 4'h8);
        repeat (10) step(4'h8, 1'b1, 1'b1, 1'b1);
        check("ch3_no_replay", btn_press, 4'h0);
        for (int i = 0; i < 20; i++) begin
            step(4'h0, 1'b1, 1'b1, 1'b1);
            if (i == 17) check("ch3_release", btn_release, 4'h8);
        end

        // single-channel active-low instance
        for (int i = 0; i < 6; i++) begin
            step(4'h0, 1'b0, 1'b1, 1'b1);
            if (i == 4) check("b_press_edge4", {3'b000, btn_level_b}, 4'h1);
        end
        step(4'h0, 1'b1, 1'b1, 1'b1);
        repeat (5) step(4'h0, 1'b0, 1'b1, 1'b1);
        check("b_glitch_rejected", {3'b000, btn_level_b}, 4'h1);
        repeat (8) step(4'h0, 1'b1, 1'b1, 1'b1);
        step(4'h0, 1'b0, 1'b1, 1'b1);
        repeat (5) step(4'h0, 1'b1, 1'b1, 1'b1);
        check("b_glitch_low", {3'b000, btn_level_b}, 4'h0);

        // random hold lengths, occasional enable drops and resets
        rv = 4'h0; r1v = 1'b1; hold1 = 0;
        for (int c = 0; c < 4; c++) hold[c] = 0;
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < 4; c++) begin
                if (hold[c] == 0) begin
                    rv[c] = ~rv[c];
                    hold[c] = $urandom_range(1, 24);
                end
                hold[c]--;
            end
            if (hold1 == 0) begin
                r1v = ~r1v;
                hold1 = $urandom_range(1, 4);
            end
            hold1--;
            en_v  = ($urandom_range(0, 7) != 0);
            rst_v = ($urandom_range(0, 199) != 0);
            step(rv, r1v, en_v, rst_v);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised, multi-channel successor to the team's single-bit registered flop.
- Each channel of raw push-button input (one per mole/pad in the whack-a-mole game) passes through three stages: a synchroniser chain, a debouncer, and an edge detector.
- Outputs per channel: a clean level, one-cycle press pulses and one-cycle release pulses.
- Sits between the board pins and the game FSM/score logic.

Parameters:
- CHANNELS, 4: number of independent button channels (>=1).
- SYNC_STAGES, 2: flops in each synchroniser chain (>=2).
- DEBOUNCE_CYCLES, 16: consecutive clk cycles a new synchronised value must persist before it is accepted (>=2). Counter width is clog2(DEBOUNCE_CYCLES).
- ACTIVE_LOW, 0: when 1, btn_raw is inverted before the synchroniser, so a pressed active-low button reads as 1 internally.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 clears state at the next rising clk edge).
- enable  in  1  when 0, press/release pulses are suppressed; debouncing continues.
- btn_raw  in  CHANNELS  asynchronous raw button inputs.
- btn_level  out  CHANNELS  debounced, registered level (1 = pressed).
- btn_press  out  CHANNELS  one-cycle pulse on a debounced 0->1 transition.
- btn_release  out  CHANNELS  one-cycle pulse on a debounced 1->0 transition.
- any_press  out  1  OR-reduction of btn_press (combinational from registers, no added latency).

Behaviour:
- Reset (reset==0 at a clk edge):
  - All synchroniser flops, debounce counters, btn_level, btn_press and btn_release go to 0; any_press therefore reads 0.
  - Reset has priority over every other event, including mid-debounce; a partial count is discarded.
- Input conditioning: inversion (if ACTIVE_LOW) happens before stage 1, so the reset value 0 always means "released".
- Synchroniser: a SYNC_STAGES-deep shift chain per channel. sync = last stage.
- Debounce, per channel, evaluated at each edge:
  - sync == btn_level: counter <= 0.
  - sync != btn_level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync != btn_level and counter == DEBOUNCE_CYCLES-1: btn_level <= sync, counter <= 0.
  - Any mismatch lasting fewer than DEBOUNCE_CYCLES consecutive cycles is rejected without changing btn_level.
- Latency:
  - Edge 0 is the first edge at which the new raw value is sampled. btn_level changes at edge SYNC_STAGES+DEBOUNCE_CYCLES-1, which is edge 17 with the defaults.
  - Raw must stay stable from edge 0 through edge 17, i.e. 18 edges, for acceptance.
- Edge pulses (registered, same edge that updates btn_level):
  - btn_press[i] <= enable & (level toggles 0->1 this edge).
  - btn_release[i] <= enable & (level toggles 1->0 this edge).
  - Pulses are high for exactly one cycle. Press and release are never high together on one channel.
- enable:
  - Sampled at the toggle edge only.
  - A transition accepted while enable==0 produces no pulse, and no pulse is deferred or replayed later.
  - btn_level updates regardless of enable.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses, and any_press is high if any press bit is high.
- No counter wrap: the counter saturates logically because it is cleared at DEBOUNCE_CYCLES-1.
- Reset release: normal operation starts at the first edge with reset==1. A button already held during reset is reported as a press once it has been debounced, at edge SYNC_STAGES+DEBOUNCE_CYCLES-1 after release, provided enable==1.

Test Plan:
- Reset: drive btn_raw=4'hF and enable=1, hold reset=0 for 5 cycles -> all outputs 0 throughout. Release reset -> btn_level=4'hF and btn_press=4'hF (one cycle) at edge 17 after release; any_press=1 for that cycle only.
- Clean press/release on ch0, defaults: raw goes 1 at edge 0 -> btn_level[0] rises and btn_press[0] pulses at edge 17. Raw goes 0 at edge 40 -> btn_release[0] pulses at edge 57.
- Bounce rejection: toggle raw[1] with high runs of 10 cycles and low runs of 3 cycles -> no run reaches 16 cycles, so btn_level[1] stays 0 and no pulses fire. Then hold it high -> accepted exactly 18 edges after the last rising transition.
- Mid-debounce reset: raw[2] high for 12 cycles, then reset=0 for 1 cycle with raw still high -> counter cleared, no pulse at the original edge 17. Press is reported 18 edges after reset deasserts.
- enable gating: enable=0 while ch3 is accepted -> btn_level[3]=1 and no press pulse. Set enable=1 and hold -> still no pulse. Release with enable=1 -> btn_release[3] pulses.
- Parameter sweep: CHANNELS=1, SYNC_STAGES=3, DEBOUNCE_CYCLES=2, ACTIVE_LOW=1. Raw driven 0 (pressed) -> btn_level=1 at edge 4. A 1-cycle raw glitch is rejected.
